// File: rtl/regfile_serializer.sv
// Multi-lane load/shift register file: captures a wide word and streams each
// lane's contiguous segment out serially, MSB- or LSB-first, one-shot or rotating.
module regfile_serializer #(
  parameter int DATA_WIDTH = 192,
  parameter int LANES      = 4,
  parameter int CNT_W      = $clog2(DATA_WIDTH / LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  en,
  input  logic                  msb_first,
  input  logic                  rotate,
  output logic [LANES-1:0]      shift_out,
  output logic                  valid_out,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_cnt
);

  localparam int SEG = DATA_WIDTH / LANES;

  typedef enum logic {EMPTY, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic             rotate_q, rotate_d;
  logic             advance;
  logic             last_bit;

  // Load wins over en, so a load with en high never advances the stream.
  assign advance  = en && (state_q == ACTIVE) && !load;
  assign last_bit = (bit_cnt_q == CNT_W'(SEG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      rotate_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      rotate_q  <= rotate_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    rotate_d  = rotate_q;
    if (load) begin
      state_d   = ACTIVE;
      bit_cnt_d = '0;
      rotate_d  = rotate;
    end else if (advance) begin
      if (last_bit) begin
        done_d    = 1'b1;
        bit_cnt_d = '0;
        if (!rotate_q) state_d = EMPTY;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign valid_out = (state_q == ACTIVE);
  assign done      = done_q;
  assign bit_cnt   = bit_cnt_q;

  // Each lane keeps its segment reordered so that bit 0 is always the head.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SEG-1:0] sr_q, sr_d, load_img;

    always_comb begin
      load_img = '0;
      for (int i = 0; i < SEG; i++) begin
        load_img[i] = msb_first ? data_in[gi*SEG + SEG - 1 - i] : data_in[gi*SEG + i];
      end
    end

    always_comb begin
      sr_d = sr_q;
      if (load) begin
        sr_d = load_img;
      end else if (advance) begin
        sr_d = {(rotate_q ? sr_q[0] : 1'b0), sr_q[SEG-1:1]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else     sr_q <= sr_d;
    end

    assign shift_out[gi] = valid_out & sr_q[0];
  end

endmodule

// File: tb/tb_regfile_serializer.sv
// Randomised and directed stimulus for regfile_serializer, checked by a
// queue-based scoreboard fed from a word/position reference model.
module tb_regfile_serializer;

  localparam int DW  = 192;
  localparam int L   = 4;
  localparam int SEG = DW / L;
  localparam int CW  = $clog2(SEG);
  localparam logic [DW-1:0] PATTERN =
    192'h123456789123456789ABCDEF123456789123456789ABCDEF;

  logic          clk = 1'b0;
  logic          rst, load, en, msb_first, rotate;
  logic [DW-1:0] data_in;
  logic [L-1:0]  shift_out;
  logic          valid_out, done;
  logic [CW-1:0] bit_cnt;

  regfile_serializer #(.DATA_WIDTH(DW), .LANES(L)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en),
    .msb_first(msb_first), .rotate(rotate), .shift_out(shift_out),
    .valid_out(valid_out), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [L-1:0]  sh;
    logic          dn;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;
  int   dones_seen = 0;
  int   invalid_seen = 0;

  // Reference model: the loaded word plus the index of the bit on display.
  logic [DW-1:0] m_word;
  logic          m_msb, m_rot, m_active;
  int            m_pos;
  logic          m_done;

  function automatic exp_t model_outputs();
    exp_t e;
    e.valid = m_active;
    e.dn    = m_done;
    e.cnt   = CW'(m_pos);
    for (int k = 0; k < L; k++) begin
      int idx;
      idx = m_msb ? (k*SEG + SEG - 1 - m_pos) : (k*SEG + m_pos);
      e.sh[k] = m_active ? m_word[idx] : 1'b0;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [DW-1:0] d,
                      input logic msb, input logic rot, input logic e);
    rst = r; load = ld; data_in = d; msb_first = msb; rotate = rot; en = e;
    m_done = 1'b0;
    if (r) begin
      m_active = 1'b0; m_pos = 0; m_word = '0; m_msb = 1'b0; m_rot = 1'b0;
    end else if (ld) begin
      m_word = d; m_msb = msb; m_rot = rot; m_active = 1'b1; m_pos = 0;
    end else if (e && m_active) begin
      if (m_pos == SEG - 1) begin
        m_done = 1'b1;
        m_pos  = 0;
        if (!m_rot) m_active = 1'b0;
      end else begin
        m_pos++;
      end
    end
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
  endtask

  task automatic idle_en(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, data_in, msb_first, rotate, e);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, n_cycle, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered output set; compare it.
  initial begin
    forever begin
      @(negedge clk);
      n_cycle++;
      if (done) dones_seen++;
      if (!valid_out) invalid_seen++;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_out", int'(valid_out), int'(e.valid));
        check("shift_out", int'(shift_out), int'(e.sh));
        check("done",      int'(done),      int'(e.dn));
        check("bit_cnt",   int'(bit_cnt),   int'(e.cnt));
      end
    end
  end

  initial begin
    int d0, i0;
    logic [DW-1:0] rnd;
    m_word = '0; m_msb = 0; m_rot = 0; m_active = 0; m_pos = 0; m_done = 0;
    data_in = '0; msb_first = 0; rotate = 0;

    // 1: reset, then en without load
    step(1, 0, '0, 0, 0, 0);
    d0 = dones_seen;
    idle_en(10, 1);
    // 2: MSB-first one-shot
    step(0, 1, PATTERN, 1, 0, 0);
    idle_en(52, 1);
    // 3: LSB-first with en gaps
    step(0, 1, PATTERN, 0, 0, 0);
    for (int i = 0; i < 150; i++) step(0, 0, PATTERN, 0, 0, (i % 3) == 0);
    // 4: rotate, 144 en edges
    step(0, 1, PATTERN, 1, 1, 0);
    @(negedge clk); #1;
    d0 = dones_seen; i0 = invalid_seen;
    idle_en(144, 1);
    @(negedge clk); #1;
    check("rotate_done_count", dones_seen - d0, 3);
    check("rotate_valid_drops", invalid_seen - i0, 0);
    // 5: reload mid-stream with zeros while en is high
    step(0, 1, PATTERN, 1, 0, 0);
    idle_en(20, 1);
    step(0, 1, '0, 1, 0, 1);
    idle_en(3, 0);
    // 6: reset mid-stream
    step(0, 1, PATTERN, 0, 1, 0);
    idle_en(30, 1);
    step(1, 0, PATTERN, 0, 1, 1);
    idle_en(8, 1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0), rnd,
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(0, 0, data_in, 0, 0, 0);

    // Drain: the monitor must consume everything within a bounded wait.
    for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_serializer.md
# regfile_serializer

Parametrised successor to the single-lane 192-bit load/shift register file. It captures a wide parallel word, then streams it out over `LANES` serial outputs. Each lane carries one contiguous segment, and the caller selects MSB-first or LSB-first order and one-shot or rotate (repeat) mode. It sits between the configuration/pattern source and the serial scan/test chains, and adds valid/done status and bit indexing so downstream logic can frame the stream.

## Interface
- `DATA_WIDTH`, default 192: parallel word width.
- `LANES`, default 4: number of serial outputs. Must divide `DATA_WIDTH`, and `SEG = DATA_WIDTH/LANES` must be ≥ 2.
- `CNT_W`, derived, `$clog2(SEG)`: width of `bit_cnt`. Not overridden.
- `clk`, input, 1: sole clock; all logic acts on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load`, input, 1: capture `data_in`, `msb_first` and `rotate` on this edge.
- `data_in`, input, `DATA_WIDTH`: parallel word. Lane k owns bits `[(k+1)*SEG-1 : k*SEG]`.
- `en`, input, 1: advance the stream by one bit per lane on this edge.
- `msb_first`, input, 1: 1 = emit the segment MSB first; 0 = emit it LSB first. Sampled only at load.
- `rotate`, input, 1: 1 = the stream repeats indefinitely; 0 = one pass, then empty. Sampled only at load.
- `shift_out`, output, `LANES`: current head bit of each lane.
- `valid_out`, output, 1: `shift_out` holds stream data.
- `done`, output, 1: one-cycle pulse when a pass of `SEG` bits completes.
- `bit_cnt`, output, `CNT_W`: index (0..SEG-1) of the bit currently on `shift_out`.

## Operation
- States:
  - EMPTY (reset state; `valid_out`=0).
  - ACTIVE (`valid_out`=1).
- Priority on each edge: `rst` > `load` > `en`.
- `load`, in any state:
  - Internal shift register ← `data_in`, reordered per lane so the first bit to emit is at the head. MSB-first head is bit `k*SEG+SEG-1`; LSB-first head is bit `k*SEG`.
  - `bit_cnt` ← 0, state → ACTIVE, mode bits latched.
  - A load in ACTIVE aborts the current stream with no `done` pulse, even if `en` is also high.
- `en` in ACTIVE, without `load`:
  - Every lane advances one position and `bit_cnt` increments.
  - Rotate mode: the bit leaving the head re-enters at the tail (circular per lane).
  - One-shot mode: a 0 enters at the tail.
- `en` on the last bit (`bit_cnt`=SEG-1):
  - One-shot: state → EMPTY, `bit_cnt` → 0, `done` pulses.
  - Rotate: state stays ACTIVE, `bit_cnt` wraps to 0 (the register has returned to its loaded image), `done` pulses.
- `en` low: everything holds, with no bit loss across gaps.
- `en` in EMPTY: ignored; outputs stay at their idle values.
- Lanes never interact; each lane's segment is independent.
- `shift_out` is forced to 0 whenever `valid_out`=0.

## Timing
- Reset values: `shift_out`=0, `valid_out`=0, `done`=0, `bit_cnt`=0, state EMPTY. The internal register clears to 0.
- Reset mid-stream: the stream is discarded, and the next cycle shows reset values with no `done` pulse.
- Load latency: `load` sampled at edge N gives first bits on `shift_out` with `valid_out`=1 and `bit_cnt`=0 during cycle N+1. No extra pipeline stage.
- Each `en` edge exposes the next bit in the following cycle.
- Throughput: with `en` held high, one pass takes exactly `SEG` edges from the first `en` edge.
- `done` timing: high for exactly the one cycle after the edge that consumes bit SEG-1.
  - One-shot: `valid_out` falls in that same cycle.
  - Rotate: `valid_out` stays 1 and bit 0 is shown again.
- Changing `msb_first` or `rotate` while ACTIVE has no effect until the next load.
- All outputs are registered or decoded from registers only, so there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `DATA_WIDTH`=192, `LANES`=4, `SEG`=48, `data_in`=192'h123456789123456789ABCDEF123456789123456789ABCDEF.
1. Reset, then `en`=1 for 10 cycles with no load → `valid_out`=0, `shift_out`=0, `bit_cnt`=0, `done` never asserted.
2. Load with `msb_first`=1, `rotate`=0, then `en`=1 → cycle 1:
   - lane 3 first bits 0,0,0,1 (from 0x1); lane 0 first bits 0,1,0,0 (from 0x4 of …456789ABCDEF).
   - 48 bits per lane match the segment MSB→LSB.
   - `done`=1 exactly one cycle after the 48th `en` edge, with `valid_out`=0 in that same cycle.
3. Load with `msb_first`=0, then `en` toggled 1,0,0,1,… → lane 0 emits 1,1,1,1,0,1,1,1 (from 0xF, 0xE). `bit_cnt` and `shift_out` hold through the low cycles, and the full 48 bits still arrive.
4. Load with `rotate`=1, then `en` held for 144 cycles → the identical 48-bit sequence repeats 3×, `done` pulses at 48, 96 and 144, and `valid_out` never drops.
5. Load at `bit_cnt`=20 with new data 192'h0 while `en`=1 → the next cycle shows `bit_cnt`=0, all `shift_out`=0, `valid_out`=1, and no `done` pulse.
6. Assert `rst` at `bit_cnt`=30 while `en`=1 → the next cycle shows all outputs at reset values, and a later `en` with no load produces no output.
